sopc_boot_ctrl: RTL and testbench
=================================

// Module: sopc_boot_ctrl
// PURPOSE
// - Synthesizable boot/run sequencer for the minimal SOPC; replaces fixed-delay bench reset and $readmemh preload.
// - Holds CPU in reset, copies an image from a source memory into instruction RAM, then releases the CPU.
// - Terminates a run on CPU halt or cycle-limit timeout and reports the outcome.
// - Sits between the top-level clk/rst and the openmips core, instruction RAM and boot source memory.
// PARAMETERS
// - ADDR_W      10   instruction-RAM / source word-address width
// - DATA_W      32   instruction word width
// - IMG_WORDS   64   words copied per boot, 1..2**ADDR_W
// - RST_CYCLES  10   cycles cpu_rst is held in HOLD before LOAD, >=1
// - RUN_CYCLES  50   run cycle limit; 0 = no limit (timeout never fires)
// PORTS
// - clk         in   1       system clock
// - rst         in   1       synchronous reset, active high
// - start       in   1       one-cycle pulse; honoured only in IDLE or DONE
// - src_rd_en   out  1       source memory read strobe
// - src_addr    out  ADDR_W  source read address
// - src_rdata   in   DATA_W  source data, valid 1 cycle after src_rd_en
// - ram_we      out  1       instruction-RAM write enable
// - ram_addr    out  ADDR_W  instruction-RAM write address
// - ram_wdata   out  DATA_W  instruction-RAM write data
// - cpu_rst     out  1       reset to openmips core, active high
// - halt        in   1       CPU halt indication, sampled in RUN only
// - busy        out  1       high in HOLD, LOAD, RUN
// - done        out  1       run ended by halt; sticky until next start/rst
// - timeout     out  1       run ended by cycle limit; sticky until next start/rst
// - cycle_cnt   out  32      RUN cycles elapsed; frozen in DONE
// - checksum    out  DATA_W  image checksum (see CONFIGURATION)
// BEHAVIOUR
// - All outputs registered. Reset: state=IDLE, cpu_rst=1, all other outputs 0.
// - States: IDLE -> HOLD -> LOAD -> RUN -> DONE; DONE -start-> HOLD.
// - IDLE: cpu_rst=1; start -> HOLD next cycle, clears done/timeout/cycle_cnt/checksum.
// - HOLD: cpu_rst=1 for exactly RST_CYCLES cycles, then LOAD.
// - LOAD: issues reads src_addr=0..IMG_WORDS-1 on consecutive cycles (src_rd_en=1).
//   Read k issued cycle t -> ram_we=1, ram_addr=k, ram_wdata=src_rdata on cycle t+1.
//   LOAD lasts IMG_WORDS+1 cycles (last write in final cycle); cpu_rst=1 throughout.
//   Address counter is ADDR_W+1 bits; IMG_WORDS=2**ADDR_W covered without wrap.
// - RUN: cpu_rst=0; cycle_cnt +1 per RUN cycle (saturates at 2**32-1).
//   halt=1 -> DONE, done=1. cycle_cnt==RUN_CYCLES (RUN_CYCLES!=0) -> DONE, timeout=1.
//   halt and limit in same cycle -> done=1, timeout=0 (halt wins).
// - DONE: cpu_rst=1, busy=0; done/timeout/cycle_cnt held; start -> HOLD.
// - start while busy is ignored; halt outside RUN ignored.
// - rst mid-operation (any state): returns to IDLE next edge, partial image left as-is, cpu_rst=1.
// - ram_we and src_rd_en never asserted outside LOAD.
// CONFIGURATION
// - SOPC_BOOT_CHECKSUM_EN defined: checksum = DATA_W-bit wrap-around sum of all words written
//   in LOAD; cleared on start; stable from first RUN cycle.
// - Undefined: checksum tied to 0; no accumulator logic synthesised.
// TESTING
// - Reset: rst=1 for 3 cycles -> cpu_rst=1, busy=0, done=0, timeout=0, ram_we=0.
// - Boot timing: defaults, start pulse -> cpu_rst=1 for 10 HOLD + 65 LOAD cycles, 64 writes addr 0..63 with src data, then cpu_rst=0.
// - Halt: halt pulsed on RUN cycle 20 -> done=1, timeout=0, cycle_cnt=20, cpu_rst=1.
// - Timeout: halt held 0 -> timeout=1 at cycle_cnt=50; halt and limit coincident -> done=1, timeout=0.
// - Reset mid-LOAD after 30 writes: rst=1 -> IDLE, no further ram_we; new start reloads all 64 words.
// - SOPC_BOOT_CHECKSUM_EN: image word[k]=k+1, IMG_WORDS=64 -> checksum=32'h0000_0820; undefined -> 0.

Source files
------------

// File: rtl/sopc_boot_ctrl.sv
// Boot/run sequencer: holds the CPU in reset, copies the boot image into instruction RAM, then supervises the run.
// Optional image checksum enabled by defining SOPC_BOOT_CHECKSUM_EN.
module sopc_boot_ctrl #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int IMG_WORDS  = 64,
  parameter int RST_CYCLES = 10,
  parameter int RUN_CYCLES = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              src_rd_en,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0] src_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              cpu_rst,
  input  logic              halt,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [31:0]       cycle_cnt,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {S_IDLE, S_HOLD, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(IMG_WORDS - 1);
  localparam logic [31:0]     HOLD_LAST = 32'(RST_CYCLES - 1);
  localparam logic [31:0]     RUN_LIMIT = 32'(RUN_CYCLES);

  state_t            r_state, w_state_next;
  logic [31:0]       r_hold_cnt, w_hold_cnt_next;
  logic [ADDR_W:0]   r_rd_addr, w_rd_addr_next;
  logic              r_rd_en, w_rd_en_next;
  logic              r_we, w_we_next;
  logic [ADDR_W-1:0] r_wr_addr, w_wr_addr_next;
  logic              r_done, w_done_next;
  logic              r_timeout, w_timeout_next;
  logic [31:0]       r_cycle_cnt, w_cycle_cnt_next;
  logic [31:0]       w_cnt_inc;
  logic              r_cpu_rst, r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= '0;
      r_rd_addr   <= '0;
      r_rd_en     <= 1'b0;
      r_we        <= 1'b0;
      r_wr_addr   <= '0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
      r_cycle_cnt <= '0;
      r_cpu_rst   <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hold_cnt  <= w_hold_cnt_next;
      r_rd_addr   <= w_rd_addr_next;
      r_rd_en     <= w_rd_en_next;
      r_we        <= w_we_next;
      r_wr_addr   <= w_wr_addr_next;
      r_done      <= w_done_next;
      r_timeout   <= w_timeout_next;
      r_cycle_cnt <= w_cycle_cnt_next;
      r_cpu_rst   <= (w_state_next != S_RUN);
      r_busy      <= (w_state_next == S_HOLD) || (w_state_next == S_LOAD) ||
                     (w_state_next == S_RUN);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_hold_cnt_next  = r_hold_cnt;
    w_rd_addr_next   = r_rd_addr;
    w_rd_en_next     = 1'b0;
    w_we_next        = 1'b0;
    w_wr_addr_next   = r_wr_addr;
    w_done_next      = r_done;
    w_timeout_next   = r_timeout;
    w_cycle_cnt_next = r_cycle_cnt;
    w_cnt_inc        = (r_cycle_cnt == 32'hFFFF_FFFF) ? r_cycle_cnt : r_cycle_cnt + 32'd1;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_next     = S_HOLD;
          w_hold_cnt_next  = '0;
          w_done_next      = 1'b0;
          w_timeout_next   = 1'b0;
          w_cycle_cnt_next = '0;
        end
      end
      S_HOLD: begin
        if (r_hold_cnt == HOLD_LAST) begin
          w_state_next   = S_LOAD;
          w_rd_en_next   = 1'b1;
          w_rd_addr_next = '0;
        end else begin
          w_hold_cnt_next = r_hold_cnt + 32'd1;
        end
      end
      S_LOAD: begin
        // Write stage trails the read stage by one cycle; final cycle only drains the last write.
        w_we_next      = r_rd_en;
        w_wr_addr_next = r_rd_addr[ADDR_W-1:0];
        if (r_rd_en) begin
          if (r_rd_addr != LAST_ADDR) begin
            w_rd_en_next   = 1'b1;
            w_rd_addr_next = r_rd_addr + 1'b1;
          end
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        w_cycle_cnt_next = w_cnt_inc;
        if (halt) begin
          w_state_next = S_DONE;
          w_done_next  = 1'b1;
        end else if ((RUN_CYCLES != 0) && (w_cnt_inc == RUN_LIMIT)) begin
          w_state_next   = S_DONE;
          w_timeout_next = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign src_rd_en = r_rd_en;
  assign src_addr  = r_rd_addr[ADDR_W-1:0];
  assign ram_we    = r_we;
  assign ram_addr  = r_wr_addr;
  // Source memory output is already registered, so the data is forwarded straight to the RAM port.
  assign ram_wdata = src_rdata;
  assign cpu_rst   = r_cpu_rst;
  assign busy      = r_busy;
  assign done      = r_done;
  assign timeout   = r_timeout;
  assign cycle_cnt = r_cycle_cnt;

`ifdef SOPC_BOOT_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;
  logic              w_clear;

  assign w_clear = ((r_state == S_IDLE) || (r_state == S_DONE)) && start;

  always_ff @(posedge clk) begin
    if (rst)
      r_checksum <= '0;
    else if (w_clear)
      r_checksum <= '0;
    else if (r_we)
      r_checksum <= r_checksum + src_rdata;
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_sopc_boot_ctrl.sv
// Directed self-checking bench for sopc_boot_ctrl with default parameters.
module tb_sopc_boot_ctrl;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst, start, halt;
  logic              src_rd_en, ram_we, cpu_rst, busy, done, timeout;
  logic [ADDR_W-1:0] src_addr, ram_addr;
  logic [DATA_W-1:0] src_rdata, ram_wdata, checksum;
  logic [31:0]       cycle_cnt;

  logic [DATA_W-1:0] src_mem   [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram_model [0:(1<<ADDR_W)-1];

  int n_vec = 0;
  int n_err = 0;

`ifdef SOPC_BOOT_CHECKSUM_EN
  localparam logic [DATA_W-1:0] EXP_SUM = 32'h0000_0820;
`else
  localparam logic [DATA_W-1:0] EXP_SUM = 32'h0000_0000;
`endif

  sopc_boot_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .src_rd_en(src_rd_en), .src_addr(src_addr), .src_rdata(src_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .cpu_rst(cpu_rst), .halt(halt), .busy(busy), .done(done), .timeout(timeout),
    .cycle_cnt(cycle_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (src_rd_en) src_rdata <= src_mem[src_addr];
    if (ram_we) ram_model[ram_addr] <= ram_wdata;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ram();
    for (int k = 0; k < (1 << ADDR_W); k++) ram_model[k] = 32'hFFFF_FFFF;
  endtask

  // Pulse start, then wait (bounded) for the first RUN cycle.
  task automatic boot_to_run();
    int cyc;
    cyc = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    while (cpu_rst === 1'b1 && cyc < 300) begin
      step();
      cyc++;
    end
    n_vec++;
    if (cpu_rst !== 1'b0) begin
      n_err++;
      $display("FAIL boot_wait: cpu_rst=%b after %0d cycles, required 0", cpu_rst, cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; halt = 1'b0;
    repeat (3) step();
    n_vec++; if (cpu_rst !== 1'b1)  begin n_err++; $display("FAIL rst_cpu_rst: got %b want 1", cpu_rst); end
    n_vec++; if (busy !== 1'b0)     begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)     begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
    n_vec++; if (timeout !== 1'b0)  begin n_err++; $display("FAIL rst_timeout: got %b want 0", timeout); end
    n_vec++; if (ram_we !== 1'b0)   begin n_err++; $display("FAIL rst_ram_we: got %b want 0", ram_we); end
    n_vec++; if (src_rd_en !== 1'b0) begin n_err++; $display("FAIL rst_rd_en: got %b want 0", src_rd_en); end
    n_vec++; if (cycle_cnt !== 32'd0) begin n_err++; $display("FAIL rst_cycle_cnt: got %0d want 0", cycle_cnt); end
    n_vec++; if (checksum !== 32'd0) begin n_err++; $display("FAIL rst_checksum: got %h want 0", checksum); end
    rst = 1'b0;
    step();
    n_vec++; if (busy !== 1'b0 || cpu_rst !== 1'b1) begin
      n_err++; $display("FAIL idle_hold: busy=%b cpu_rst=%b want 0/1", busy, cpu_rst);
    end
    $display("reset: checked idle outputs after 3-cycle reset");
  endtask

  task automatic test_boot();
    int cyc, writes, reads, first_w, bad;
    cyc = 0; writes = 0; reads = 0; first_w = -1; bad = 0;
    for (int k = 0; k < (1 << ADDR_W); k++) src_mem[k] = 32'(k + 1);
    clear_ram();
    start = 1'b1;
    step();
    start = 1'b0;
    while (cpu_rst === 1'b1 && cyc < 300) begin
      if (busy !== 1'b1) bad++;
      if (src_rd_en === 1'b1) begin
        if (32'(src_addr) !== 32'(reads)) bad++;
        reads++;
      end
      if (ram_we === 1'b1) begin
        if (first_w < 0) first_w = cyc;
        if (32'(ram_addr) !== 32'(writes) || ram_wdata !== 32'(writes + 1)) bad++;
        writes++;
      end
      cyc++;
      step();
    end
    n_vec++; if (cyc != 75)     begin n_err++; $display("FAIL boot_rst_len: got %0d want 75", cyc); end
    n_vec++; if (reads != 64)   begin n_err++; $display("FAIL boot_reads: got %0d want 64", reads); end
    n_vec++; if (writes != 64)  begin n_err++; $display("FAIL boot_writes: got %0d want 64", writes); end
    n_vec++; if (first_w != 11) begin n_err++; $display("FAIL boot_first_write: cycle %0d want 11", first_w); end
    n_vec++; if (bad != 0)      begin n_err++; $display("FAIL boot_sequence: %0d bad cycles want 0", bad); end
    n_vec++; if (busy !== 1'b1 || ram_we !== 1'b0 || src_rd_en !== 1'b0) begin
      n_err++; $display("FAIL run_entry: busy=%b we=%b rd=%b want 1/0/0", busy, ram_we, src_rd_en);
    end
    n_vec++; if (cycle_cnt !== 32'd0) begin n_err++; $display("FAIL run_cnt0: got %0d want 0", cycle_cnt); end
    n_vec++; if (checksum !== EXP_SUM) begin n_err++; $display("FAIL checksum: got %h want %h", checksum, EXP_SUM); end
    $display("boot: %0d cpu_rst cycles, %0d writes, checksum %h", cyc, writes, checksum);
  endtask

  task automatic test_halt();
    repeat (19) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    n_vec++; if (done !== 1'b1)       begin n_err++; $display("FAIL halt_done: got %b want 1", done); end
    n_vec++; if (timeout !== 1'b0)    begin n_err++; $display("FAIL halt_timeout: got %b want 0", timeout); end
    n_vec++; if (cycle_cnt !== 32'd20) begin n_err++; $display("FAIL halt_cnt: got %0d want 20", cycle_cnt); end
    n_vec++; if (cpu_rst !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL halt_state: cpu_rst=%b busy=%b want 1/0", cpu_rst, busy);
    end
    halt = 1'b1;
    repeat (3) step();
    halt = 1'b0;
    n_vec++; if (done !== 1'b1 || cycle_cnt !== 32'd20 || busy !== 1'b0) begin
      n_err++; $display("FAIL done_sticky: done=%b cnt=%0d busy=%b want 1/20/0", done, cycle_cnt, busy);
    end
    $display("halt: done=%b timeout=%b cycle_cnt=%0d", done, timeout, cycle_cnt);
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++; if (done !== 1'b0 || cycle_cnt !== 32'd0 || busy !== 1'b1) begin
      n_err++; $display("FAIL restart_clear: done=%b cnt=%0d busy=%b want 0/0/1", done, cycle_cnt, busy);
    end
    while (cpu_rst === 1'b1 && n < 300) begin step(); n++; end
    repeat (4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    n_vec++; if (busy !== 1'b1 || cpu_rst !== 1'b0) begin
      n_err++; $display("FAIL start_ignored: busy=%b cpu_rst=%b want 1/0", busy, cpu_rst);
    end
    n = 0;
    while (timeout !== 1'b1 && done !== 1'b1 && n < 200) begin step(); n++; end
    n_vec++; if (n != 45)            begin n_err++; $display("FAIL to_cycles: got %0d want 45", n); end
    n_vec++; if (timeout !== 1'b1)   begin n_err++; $display("FAIL to_flag: got %b want 1", timeout); end
    n_vec++; if (done !== 1'b0)      begin n_err++; $display("FAIL to_done: got %b want 0", done); end
    n_vec++; if (cycle_cnt !== 32'd50) begin n_err++; $display("FAIL to_cnt: got %0d want 50", cycle_cnt); end
    $display("timeout: timeout=%b done=%b cycle_cnt=%0d", timeout, done, cycle_cnt);
  endtask

  task automatic test_coincident();
    boot_to_run();
    repeat (49) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    n_vec++; if (done !== 1'b1 || timeout !== 1'b0) begin
      n_err++; $display("FAIL coincide_flags: done=%b timeout=%b want 1/0", done, timeout);
    end
    n_vec++; if (cycle_cnt !== 32'd50) begin n_err++; $display("FAIL coincide_cnt: got %0d want 50", cycle_cnt); end
    $display("coincident: done=%b timeout=%b cycle_cnt=%0d", done, timeout, cycle_cnt);
  endtask

  task automatic test_reset_mid_load();
    int cyc, writes, stray, bad;
    cyc = 0; writes = 0; stray = 0; bad = 0;
    clear_ram();
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < 300) begin
      if (ram_we === 1'b1) writes++;
      if (writes == 30) break;
      step();
      cyc++;
    end
    rst = 1'b1;
    step();
    n_vec++; if (ram_we !== 1'b0 || src_rd_en !== 1'b0 || busy !== 1'b0 || cpu_rst !== 1'b1) begin
      n_err++; $display("FAIL midrst_state: we=%b rd=%b busy=%b cpu_rst=%b want 0/0/0/1",
                        ram_we, src_rd_en, busy, cpu_rst);
    end
    step();
    rst = 1'b0;
    repeat (5) begin
      step();
      if (ram_we !== 1'b0) stray++;
    end
    n_vec++; if (stray != 0) begin n_err++; $display("FAIL midrst_stray_we: %0d writes want 0", stray); end
    n_vec++; if (ram_model[29] !== 32'd30 || ram_model[30] !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL midrst_partial: ram[29]=%h ram[30]=%h want 1e/ffffffff",
                        ram_model[29], ram_model[30]);
    end
    for (int k = 0; k < (1 << ADDR_W); k++) src_mem[k] = 32'hC0DE_0000 ^ 32'(k);
    boot_to_run();
    for (int k = 0; k < 64; k++) if (ram_model[k] !== (32'hC0DE_0000 ^ 32'(k))) bad++;
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL reload_image: %0d bad words want 0", bad); end
    n_vec++; if (ram_model[64] !== 32'hFFFF_FFFF) begin
      n_err++; $display("FAIL reload_overrun: ram[64]=%h want ffffffff", ram_model[64]);
    end
    $display("reset_mid_load: %0d writes before rst, reload bad words %0d", writes, bad);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0;
    test_reset();
    test_boot();
    test_halt();
    test_timeout();
    test_coincident();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
